anc_sequencer: RTL
==================

# anc_sequencer

Per-sample scheduler for the adaptive noise-cancellation datapath. On each incoming audio sample strobe it sequences the three stages in order: lowpass filter, LMS coefficient update, then FIR anti-noise filter. It uses start/done handshakes and signals when the anti-noise output is valid. It also gates adaptation during buffer warm-up or when adaptation is disabled, and it detects sample overruns.

## Interface
Parameters:
- WARMUP_SAMPLES, 256: completed samples before LMS updates are allowed (sample buffer depth).
- TIMEOUT_CYCLES, 1024: maximum cycles any stage may stay busy (used only with watchdog).

Ports:
- clk_in  input  1  system clock; one clock domain.
- rst_in  input  1  synchronous, active-high reset.
- sample_strobe_in  input  1  one-cycle pulse: new ADC sample available.
- adapt_en_in  input  1  level; 1 allows LMS updates after warm-up.
- lp_start_out  output  1  one-cycle start pulse to lowpass.
- lp_done_in  input  1  lowpass completion pulse.
- lms_start_out  output  1  one-cycle start pulse to LMS.
- lms_done_in  input  1  LMS completion pulse.
- fir_start_out  output  1  one-cycle start pulse to FIR.
- fir_done_in  input  1  FIR completion pulse.
- out_valid_out  output  1  one-cycle pulse: anti-noise sample valid.
- busy_out  output  1  high whenever state ≠ IDLE.
- warmup_done_out  output  1  high once WARMUP_SAMPLES samples have completed.
- overrun_out  output  1  one-cycle pulse when a sample is dropped.
- overrun_count_out  output  16  saturating count of dropped samples.
- timeout_out  output  1  one-cycle pulse on watchdog abort (tied 0 without watchdog).

## Operation
- States:
  - IDLE, LP, LMS, FIR, DONE.
  - Each start output is registered and high only in the first cycle of its state.
- IDLE:
  - strobe or pending → LP.
  - Pending is cleared when consumed.
- LP:
  - lp_done_in → LMS if adapt_en_in && warmup_done_out; otherwise → FIR (LMS skipped).
- LMS: lms_done_in → FIR.
- FIR: fir_done_in → DONE.
- DONE:
  - out_valid_out = 1 for this one cycle.
  - Sample counter increments, saturating at WARMUP_SAMPLES.
  - Next state: strobe or pending → LP; otherwise → IDLE.
- Done inputs are ignored outside their matching state.
  - Stray or early done pulses have no effect.
- Strobe while in LP, LMS or FIR:
  - If pending = 0, set pending.
  - If pending = 1, pulse overrun_out and increment overrun_count_out (saturating at 16'hFFFF); the sample is dropped.
- Strobe in DONE with pending already set: start one sample, keep pending = 1, no overrun.
- adapt_en_in is sampled only on the LP exit cycle.
- Reset (any state, mid-operation):
  - Next cycle: state IDLE, pending 0, counters 0.
  - Outputs after reset: every output 0 (warmup_done_out 0).

## Timing
- Strobe in IDLE at cycle t → lp_start_out at t+1.
- lp_done_in at cycle u → lms_start_out (or fir_start_out) at u+1.
- fir_done_in at cycle v → out_valid_out at v+1.
- Scheduler overhead is 4 cycles per sample (3 with LMS skipped), plus stage latencies.
- Back-to-back: pending or strobe in DONE → lp_start_out the cycle after DONE, with no IDLE cycle.
- warmup_done_out rises in the cycle after the DONE cycle of sample WARMUP_SAMPLES.

## Configuration
- ANC_WATCHDOG_EN defined:
  - A cycle counter clears on entry to LP, LMS or FIR.
  - If the counter reaches TIMEOUT_CYCLES-1 without the matching done: next state IDLE, timeout_out pulses for one cycle.
  - No out_valid_out for that sample; pending is preserved; the sample counter is not incremented.
- ANC_WATCHDOG_EN undefined:
  - No counter logic; timeout_out is tied 0.
  - A stage that never completes hangs the sequencer until reset.

## Structure
- Shared package anc_pkg:
  - state enum type anc_seq_state_t;
  - default constants ANC_WARMUP_SAMPLES and ANC_TIMEOUT_CYCLES;
  - overrun counter width constant (16).
- One sub-module: anc_watchdog (counter, clear, expire pulse), instantiated only under ANC_WATCHDOG_EN.

## Test plan
- Reset, then a single strobe with done pulses 5 cycles after each start, adapt_en_in=1, warm-up incomplete → lp_start, fir_start, out_valid only; no lms_start; busy high for exactly the sequence.
- Force sample count to 256 via 256 sequences with adapt_en_in=1 → 257th sample issues lms_start_out one cycle after lp_done_in; warmup_done_out is high.
- Two strobes during FIR → first sets pending, second pulses overrun_out, overrun_count_out=1; pending sample starts lp_start the cycle after DONE.
- Stray lms_done_in and fir_done_in in IDLE and LP → no state change, no out_valid_out.
- rst_in asserted in LMS with pending set → next cycle IDLE, all outputs 0, a following strobe restarts normally.
- With ANC_WATCHDOG_EN and TIMEOUT_CYCLES=16, withhold fir_done_in → timeout_out at FIR cycle 16, return to IDLE, no out_valid_out.

Source files
------------

// File: rtl/anc_pkg.sv
// ============================================================================
// Module      : anc_pkg
// Description : Shared types and default constants for the ANC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package anc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LP   = 3'd1,
        ST_LMS  = 3'd2,
        ST_FIR  = 3'd3,
        ST_DONE = 3'd4
    } anc_seq_state_t;

    localparam int ANC_WARMUP_SAMPLES = 256;
    localparam int ANC_TIMEOUT_CYCLES = 1024;
    localparam int ANC_OVR_CNT_W      = 16;

endpackage

`default_nettype wire

// File: rtl/anc_watchdog.sv
// ============================================================================
// Module      : anc_watchdog
// Description : Stage-busy cycle counter; flags expiry at TIMEOUT_CYCLES-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module anc_watchdog
    import anc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = ANC_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic active_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear lands on the first cycle of a stage, so cycle k of a stage reads k-1.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (active_i && (count_q != C_LIMIT)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = active_i && (count_q == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/anc_sequencer.sv
// ============================================================================
// Module      : anc_sequencer
// Description : Per-sample LP -> LMS -> FIR scheduler with warm-up gating and
//               overrun detection. Optional watchdog: ANC_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module anc_sequencer
    import anc_pkg::*;
#(
    parameter int WARMUP_SAMPLES = ANC_WARMUP_SAMPLES,
    parameter int TIMEOUT_CYCLES = ANC_TIMEOUT_CYCLES
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     sample_strobe_in,
    input  logic                     adapt_en_in,
    output logic                     lp_start_out,
    input  logic                     lp_done_in,
    output logic                     lms_start_out,
    input  logic                     lms_done_in,
    output logic                     fir_start_out,
    input  logic                     fir_done_in,
    output logic                     out_valid_out,
    output logic                     busy_out,
    output logic                     warmup_done_out,
    output logic                     overrun_out,
    output logic [ANC_OVR_CNT_W-1:0] overrun_count_out,
    output logic                     timeout_out
);

    localparam int SCNT_W = (WARMUP_SAMPLES > 0) ? $clog2(WARMUP_SAMPLES + 1) : 1;
    localparam logic [SCNT_W-1:0] C_WARM_LIMIT = SCNT_W'(WARMUP_SAMPLES);

    anc_seq_state_t state_q, state_d;
    logic                     pending_q, pending_d;
    logic                     overrun_q, overrun_d;
    logic [ANC_OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;
    logic [SCNT_W-1:0]        sample_cnt_q, sample_cnt_d;
    logic                     lp_start_q, lp_start_d;
    logic                     lms_start_q, lms_start_d;
    logic                     fir_start_q, fir_start_d;

    logic in_stage;
    logic warmup_done;
    logic timeout;

    assign in_stage    = (state_q == ST_LP) || (state_q == ST_LMS) || (state_q == ST_FIR);
    assign warmup_done = (sample_cnt_q == C_WARM_LIMIT);

`ifdef ANC_WATCHDOG_EN
    logic stage_done;
    logic wd_clear;
    logic wd_expire;

    assign stage_done = ((state_q == ST_LP)  && lp_done_in)  ||
                        ((state_q == ST_LMS) && lms_done_in) ||
                        ((state_q == ST_FIR) && fir_done_in);
    assign wd_clear   = (state_d != state_q) &&
                        ((state_d == ST_LP) || (state_d == ST_LMS) || (state_d == ST_FIR));

    anc_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .clear_i  (wd_clear),
        .active_i (in_stage),
        .expire_o (wd_expire)
    );

    // A done arriving on the expiry cycle still wins.
    assign timeout = wd_expire && !stage_done;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        overrun_d    = 1'b0;
        ovr_cnt_d    = ovr_cnt_q;
        sample_cnt_d = sample_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (sample_strobe_in || pending_q) begin
                    state_d   = ST_LP;
                    pending_d = pending_q && sample_strobe_in;
                end
            end
            ST_LP: begin
                if (lp_done_in) begin
                    state_d = (adapt_en_in && warmup_done) ? ST_LMS : ST_FIR;
                end
            end
            ST_LMS: begin
                if (lms_done_in) begin
                    state_d = ST_FIR;
                end
            end
            ST_FIR: begin
                if (fir_done_in) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!warmup_done) begin
                    sample_cnt_d = sample_cnt_q + SCNT_W'(1);
                end
                // A strobe here with a sample already pending starts one and keeps the other queued.
                if (sample_strobe_in || pending_q) begin
                    state_d   = ST_LP;
                    pending_d = pending_q && sample_strobe_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (in_stage && sample_strobe_in) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
                if (ovr_cnt_q != '1) begin
                    ovr_cnt_d = ovr_cnt_q + ANC_OVR_CNT_W'(1);
                end
            end
        end

        if (timeout) begin
            state_d = ST_IDLE;
        end
    end

    assign lp_start_d  = (state_d == ST_LP)  && (state_q != ST_LP);
    assign lms_start_d = (state_d == ST_LMS) && (state_q != ST_LMS);
    assign fir_start_d = (state_d == ST_FIR) && (state_q != ST_FIR);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            ovr_cnt_q    <= '0;
            sample_cnt_q <= '0;
            lp_start_q   <= 1'b0;
            lms_start_q  <= 1'b0;
            fir_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            ovr_cnt_q    <= ovr_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            lp_start_q   <= lp_start_d;
            lms_start_q  <= lms_start_d;
            fir_start_q  <= fir_start_d;
        end
    end

    assign lp_start_out      = lp_start_q;
    assign lms_start_out     = lms_start_q;
    assign fir_start_out     = fir_start_q;
    assign out_valid_out     = (state_q == ST_DONE);
    assign busy_out          = (state_q != ST_IDLE);
    assign warmup_done_out   = warmup_done;
    assign overrun_out       = overrun_q;
    assign overrun_count_out = ovr_cnt_q;
    assign timeout_out       = timeout;

endmodule

`default_nettype wire
